// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch (I) and data (D) ports.
// D is preferred; I is forced after MAX_WAIT D grants. A stuck memory is timed out.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [3:0]        TMO_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_r;
    logic [3:0]        tmo_r;
    logic              grant_i_s;
    logic              grant_d_s;

    assign if_stall  = i_req & ~i_ack;
    assign mem_stall = d_req & ~d_ack;

    // Winner selection: D by default, I when it has waited out MAX_WAIT D grants
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (i_req && (!d_req || (wait_r == WAIT_MAX))) begin
            grant_i_s = 1'b1;
        end else if (d_req) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM with registered memory-side and pipeline-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_r      <= {WAIT_W{1'b0}};
            tmo_r       <= 4'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= {DATA_W{1'b0}};
            d_rdata     <= {DATA_W{1'b0}};
            err_timeout <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        state_r   <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= {DATA_W{1'b0}};
                        wait_r    <= {WAIT_W{1'b0}};
                        tmo_r     <= 4'd0;
                    end else if (grant_d_s) begin
                        state_r   <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        tmo_r     <= 4'd0;
                        if (i_req && (wait_r != WAIT_MAX)) begin
                            wait_r <= wait_r + WAIT_ONE;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Completion and timeout both release the owner with an ack
                    if (mem_ready || (tmo_r == TMO_LAST)) begin
                        state_r <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_ready) begin
                            err_timeout <= 1'b1;
                        end
                        if (state_r == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : {DATA_W{1'b0}};
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_ready ? mem_rdata : {DATA_W{1'b0}};
                        end
                    end else begin
                        tmo_r <= tmo_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-configurable memory responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, if_stall, mem_stall;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, err_timeout;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit resp_en = 1'b1;
    bit spur = 1'b0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory model: answers with addr^0x5A5A one cycle after seeing mem_req
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = spur;
            if (mem_req === 1'b1 && resp_en) begin
                if (cnt == 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr ^ 16'h5A5A;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        int dcnt, busy;
        bit got, early_err;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_err", 32'(err_timeout), 32'd0);
        check_val("rst_acks", 32'({i_ack, d_ack}), 32'd0);

        // 1: fetch only
        i_req = 1'b1; i_addr = 16'h1234;
        tick();
        check_val("t1_mem_req", 32'(mem_req), 32'd1);
        check_val("t1_mem_addr", 32'(mem_addr), 32'h1234);
        check_val("t1_mem_we", 32'(mem_we), 32'd0);
        check_val("t1_if_stall", 32'(if_stall), 32'd1);
        tick();
        check_val("t1_ready_no_ack", 32'(i_ack), 32'd0);
        check_val("t1_if_stall2", 32'(if_stall), 32'd1);
        tick();
        check_val("t1_i_ack", 32'(i_ack), 32'd1);
        check_val("t1_i_rdata", 32'(i_rdata), 32'h486E);
        check_val("t1_if_stall_ack", 32'(if_stall), 32'd0);
        check_val("t1_mem_req_off", 32'(mem_req), 32'd0);
        i_req = 1'b0;
        tick();
        check_val("t1_ack_pulse", 32'(i_ack), 32'd0);

        // 2: simultaneous requests, D wins
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        tick();
        check_val("t2_d_we", 32'(mem_we), 32'd1);
        check_val("t2_d_addr", 32'(mem_addr), 32'h0040);
        check_val("t2_d_wdata", 32'(mem_wdata), 32'hBEEF);
        check_val("t2_mem_stall", 32'(mem_stall), 32'd1);
        tick();
        tick();
        check_val("t2_d_ack", 32'({i_ack, d_ack}), 32'b01);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check_val("t2_i_grant", 32'({mem_req, mem_we}), 32'b10);
        check_val("t2_i_addr", 32'(mem_addr), 32'h0100);
        tick();
        tick();
        check_val("t2_i_ack", 32'(i_ack), 32'd1);
        check_val("t2_i_rdata", 32'(i_rdata), 32'h5B5A);
        i_req = 1'b0;
        tick();

        // 3: starvation guard
        i_req = 1'b1; i_addr = 16'h0200;
        d_req = 1'b1; d_addr = 16'h0300;
        dcnt = 0; got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (d_ack) dcnt++;
            if (i_ack) got = 1'b1;
        end
        check_val("t3_i_acked", 32'(got), 32'd1);
        check_val("t3_d_count", 32'(dcnt), 32'd3);
        check_val("t3_i_rdata", 32'(i_rdata), 32'h585A);
        check_val("t3_d_rdata", 32'(d_rdata), 32'h595A);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        check_val("t3_idle", 32'(mem_req), 32'd0);

        // 4: memory never answers
        resp_en = 1'b0;
        d_req = 1'b1; d_addr = 16'h0400;
        busy = 0; got = 1'b0; early_err = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (mem_req) busy++;
            if (d_ack) got = 1'b1;
            else if (err_timeout) early_err = 1'b1;
        end
        check_val("t4_acked", 32'(got), 32'd1);
        check_val("t4_busy_cycles", 32'(busy), 32'd15);
        check_val("t4_early_err", 32'(early_err), 32'd0);
        check_val("t4_err", 32'(err_timeout), 32'd1);
        check_val("t4_rdata", 32'(d_rdata), 32'h0000);
        check_val("t4_mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0; resp_en = 1'b1;
        repeat (3) tick();
        check_val("t4_err_sticky", 32'(err_timeout), 32'd1);

        // 6: spurious mem_ready in IDLE
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check_val("t6_ready_seen", 32'(mem_ready), 32'd1);
        tick();
        check_val("t6_no_ack", 32'({i_ack, d_ack}), 32'b00);
        check_val("t6_idle", 32'(mem_req), 32'd0);
        tick();
        check_val("t6_no_ack2", 32'({i_ack, d_ack}), 32'b00);

        // 5: reset during BUSY_D
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_err_cleared", 32'(err_timeout), 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
        tick();
        check_val("t5_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_rst_outputs", 32'({mem_req, mem_we, d_ack, i_ack}), 32'd0);
        check_val("t5_rst_addr", 32'(mem_addr), 32'h0000);
        check_val("t5_rst_rdata", 32'(d_rdata), 32'h0000);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (d_ack) got = 1'b1;
        end
        check_val("t5_reacked", 32'(got), 32'd1);
        check_val("t5_rdata", 32'(d_rdata), 32'h5F5A);
        d_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
